// File: rtl/pipe_stage_reg.sv
// Pipeline register between CPU stages. Carries instruction, PC, delay-slot
// flag and exception code with a valid bit. It has two behaviours:
//   MODE=0 : stall-enable register with flush-to-bubble (in_ready = ~stall).
//   MODE=1 : valid/ready stage with a main entry and a one-deep skid entry,
//            giving full throughput and a registered in_ready.
// Payload fields are copied verbatim. A bubble zeroes instr/bd/exc and keeps
// the incoming PC, so the bubble still carries a usable EPC candidate.
module pipe_stage_reg #(
  parameter int unsigned           INSTR_W          = 32,
  parameter int unsigned           PC_W             = 32,
  parameter int unsigned           EXC_W            = 5,
  parameter logic [PC_W-1:0]       RESET_PC         = PC_W'(32'h0000_3000),
  parameter int unsigned           MODE             = 0,
  parameter bit                    FLUSH_OVER_STALL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_bd,
  input  logic [EXC_W-1:0]   in_exc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_bd,
  output logic [EXC_W-1:0]   out_exc,
  output logic [1:0]         occupancy
);

  // Packed payload layout: {instr, pc, bd, exc}
  localparam int unsigned PW = INSTR_W + PC_W + 1 + EXC_W;

  logic [PW-1:0] in_data;
  logic [PW-1:0] bubble_data;
  logic [PW-1:0] reset_data;

  assign in_data     = {in_instr, in_pc, in_bd, in_exc};
  assign bubble_data = {{INSTR_W{1'b0}}, in_pc, 1'b0, {EXC_W{1'b0}}};
  assign reset_data  = {{INSTR_W{1'b0}}, RESET_PC, 1'b0, {EXC_W{1'b0}}};

  logic [PW-1:0] main_data_reg;

  assign out_instr = main_data_reg[PW-1 -: INSTR_W];
  assign out_pc    = main_data_reg[EXC_W+1 +: PC_W];
  assign out_bd    = main_data_reg[EXC_W];
  assign out_exc   = main_data_reg[EXC_W-1:0];

  generate
    if (MODE == 0) begin : g_stall_reg
      logic valid_reg;
      logic do_flush;
      logic unused_out_ready;

      // Downstream readiness has no meaning for a lock-step stage.
      assign unused_out_ready = out_ready;

      // Resolve stall/flush collision according to the chosen priority.
      assign do_flush = FLUSH_OVER_STALL ? flush : (flush & ~stall);

      assign in_ready  = ~stall;
      assign out_valid = valid_reg;
      assign occupancy = {1'b0, valid_reg};

      // Bubble on flush, hold on stall, otherwise capture the upstream beat.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg     <= 1'b0;
          main_data_reg <= reset_data;
        end else if (do_flush) begin
          valid_reg     <= 1'b0;
          main_data_reg <= bubble_data;
        end else if (!stall) begin
          valid_reg     <= in_valid;
          main_data_reg <= in_data;
        end
      end
    end else begin : g_skid_reg
      logic          main_valid_reg, main_valid_next;
      logic [PW-1:0] main_data_next;
      logic          skid_valid_reg, skid_valid_next;
      logic [PW-1:0] skid_data_reg, skid_data_next;
      logic          in_ready_reg;
      logic [1:0]    occupancy_reg;
      logic          accept;
      logic          emit;
      logic          unused_stall;

      // A handshake stage never stalls by command; backpressure is out_ready.
      assign unused_stall = stall;

      assign accept    = in_valid & in_ready_reg;
      assign emit      = main_valid_reg & out_ready;

      assign in_ready  = in_ready_reg;
      assign out_valid = main_valid_reg;
      assign occupancy = occupancy_reg;

      // Next-state for the main/skid pair. The skid entry is only ever
      // filled when main is occupied and blocked, so skid valid implies main
      // valid and no accept can happen while skid is full.
      always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (flush) begin
          main_valid_next = 1'b0;
          main_data_next  = bubble_data;
          skid_valid_next = 1'b0;
          skid_data_next  = '0;
        end else if (skid_valid_reg) begin
          if (emit) begin
            main_data_next  = skid_data_reg;
            skid_valid_next = 1'b0;
          end
        end else if (main_valid_reg) begin
          if (accept && emit) begin
            main_data_next = in_data;
          end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
          end else if (emit) begin
            main_valid_next = 1'b0;
          end
        end else if (accept) begin
          main_valid_next = 1'b1;
          main_data_next  = in_data;
        end
      end

      // Register entries, the ready flag and the occupancy count together.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          main_valid_reg <= 1'b0;
          main_data_reg  <= reset_data;
          skid_valid_reg <= 1'b0;
          skid_data_reg  <= '0;
          in_ready_reg   <= 1'b1;
          occupancy_reg  <= 2'd0;
        end else begin
          main_valid_reg <= main_valid_next;
          main_data_reg  <= main_data_next;
          skid_valid_reg <= skid_valid_next;
          skid_data_reg  <= skid_data_next;
          in_ready_reg   <= ~skid_valid_next;
          occupancy_reg  <= {skid_valid_next, main_valid_next & ~skid_valid_next};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two MODE=0 instances (flush-over-stall
// and stall-over-flush) and one MODE=1 skid instance sharing the stimulus.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_bd;
  logic [4:0]  in_exc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_bd;
  logic [31:0] a_out_instr, a_out_pc;
  logic [4:0]  a_out_exc;
  logic [1:0]  a_occ;

  logic        b_in_ready, b_out_valid, b_out_bd;
  logic [31:0] b_out_instr, b_out_pc;
  logic [4:0]  b_out_exc;
  logic [1:0]  b_occ;

  logic        c_in_ready, c_out_valid, c_out_bd;
  logic [31:0] c_out_instr, c_out_pc;
  logic [4:0]  c_out_exc;
  logic [1:0]  c_occ;

  int n_cmp;
  int n_err;

  pipe_stage_reg #(.MODE(0), .FLUSH_OVER_STALL(1'b1)) u_fos (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .out_pc(a_out_pc), .out_bd(a_out_bd), .out_exc(a_out_exc),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.MODE(0), .FLUSH_OVER_STALL(1'b0)) u_sof (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .out_bd(b_out_bd), .out_exc(b_out_exc),
    .occupancy(b_occ)
  );

  pipe_stage_reg #(.MODE(1)) u_skid (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_instr(c_out_instr),
    .out_pc(c_out_pc), .out_bd(c_out_bd), .out_exc(c_out_exc),
    .occupancy(c_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic bd, input logic [4:0] exc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
    in_bd    = bd;
    in_exc   = exc;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);

    // ---------------- MODE=0 ----------------
    tick();
    tick();
    check_eq("m0 reset valid", a_out_valid, 0);
    check_eq("m0 reset pc", a_out_pc, 32'h3000);
    check_eq("m0 reset instr", a_out_instr, 0);
    check_eq("m0 reset occ", a_occ, 0);
    check_eq("m0 reset in_ready", a_in_ready, 1);
    reset = 1'b0;

    drive(1'b1, 32'h3c01_1234, 32'h3000, 1'b0, 5'd0);
    tick();
    check_eq("m0 load instr", a_out_instr, 32'h3c01_1234);
    check_eq("m0 load pc", a_out_pc, 32'h3000);
    check_eq("m0 load valid", a_out_valid, 1);
    check_eq("m0 load occ", a_occ, 1);

    drive(1'b1, 32'h0000_0021, 32'h3004, 1'b1, 5'd3);
    tick();
    check_eq("m0 load2 instr", a_out_instr, 32'h21);
    check_eq("m0 load2 bd", a_out_bd, 1);
    check_eq("m0 load2 exc", a_out_exc, 3);

    // Plain stall: both variants hold.
    stall = 1'b1;
    drive(1'b1, 32'hdead_beef, 32'h3008, 1'b0, 5'd0);
    #1;
    check_eq("m0 in_ready under stall", a_in_ready, 0);
    tick();
    check_eq("m0 stall hold instr", a_out_instr, 32'h21);
    check_eq("m0 stall hold pc", a_out_pc, 32'h3004);

    // Stall and flush together: the two priorities diverge.
    flush = 1'b1;
    tick();
    check_eq("fos bubble instr", a_out_instr, 0);
    check_eq("fos bubble valid", a_out_valid, 0);
    check_eq("fos bubble pc", a_out_pc, 32'h3008);
    check_eq("fos bubble bd", a_out_bd, 0);
    check_eq("fos bubble exc", a_out_exc, 0);
    check_eq("sof hold instr", b_out_instr, 32'h21);
    check_eq("sof hold pc", b_out_pc, 32'h3004);
    check_eq("sof hold valid", b_out_valid, 1);
    check_eq("sof hold exc", b_out_exc, 3);

    // Flush alone bubbles both variants.
    stall = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'h300c, 1'b1, 5'd4);
    tick();
    check_eq("sof flush valid", b_out_valid, 0);
    check_eq("sof flush pc", b_out_pc, 32'h300c);
    check_eq("sof flush instr", b_out_instr, 0);

    // Loading an invalid beat leaves the stage empty.
    flush = 1'b0;
    drive(1'b0, 32'h5555_aaaa, 32'h3010, 1'b0, 5'd0);
    tick();
    check_eq("m0 invalid load valid", a_out_valid, 0);
    check_eq("m0 invalid load occ", a_occ, 0);
    check_eq("m0 invalid load instr", a_out_instr, 32'h5555_aaaa);

    // Async reset between edges with a valid beat held.
    drive(1'b1, 32'h0000_0abc, 32'h3014, 1'b0, 5'd0);
    tick();
    check_eq("m0 pre-reset valid", a_out_valid, 1);
    #3 reset = 1'b1;
    #1;
    check_eq("m0 async reset valid", a_out_valid, 0);
    check_eq("m0 async reset pc", a_out_pc, 32'h3000);
    #1 reset = 1'b0;

    // ---------------- MODE=1 ----------------
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    #2 reset = 1'b0;
    check_eq("m1 reset in_ready", c_in_ready, 1);
    check_eq("m1 reset occ", c_occ, 0);
    check_eq("m1 reset valid", c_out_valid, 0);
    check_eq("m1 reset pc", c_out_pc, 32'h3000);

    // Skid fill under backpressure.
    drive(1'b1, 32'haaaa_0001, 32'h3000, 1'b0, 5'd0);
    tick();
    check_eq("m1 A occ", c_occ, 1);
    check_eq("m1 A in_ready", c_in_ready, 1);
    drive(1'b1, 32'hbbbb_0002, 32'h3004, 1'b1, 5'd2);
    tick();
    check_eq("m1 AB occ", c_occ, 2);
    check_eq("m1 AB in_ready", c_in_ready, 0);
    check_eq("m1 AB out instr", c_out_instr, 32'haaaa_0001);
    drive(1'b1, 32'hcccc_0003, 32'h3008, 1'b0, 5'd0);
    tick();
    check_eq("m1 backpressure instr", c_out_instr, 32'haaaa_0001);
    check_eq("m1 backpressure occ", c_occ, 2);

    // Drain: A goes out, then B.
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("m1 drain B instr", c_out_instr, 32'hbbbb_0002);
    check_eq("m1 drain B bd", c_out_bd, 1);
    check_eq("m1 drain B exc", c_out_exc, 2);
    check_eq("m1 drain occ", c_occ, 1);
    check_eq("m1 drain in_ready", c_in_ready, 1);
    tick();
    check_eq("m1 empty valid", c_out_valid, 0);
    check_eq("m1 empty occ", c_occ, 0);

    // Streaming with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + i, 32'h3000 + 4 * i, 1'b0, 5'd0);
      check_eq($sformatf("m1 stream in_ready %0d", i), c_in_ready, 1);
      tick();
      check_eq($sformatf("m1 stream valid %0d", i), c_out_valid, 1);
      check_eq($sformatf("m1 stream pc %0d", i), c_out_pc, 32'h3000 + 4 * i);
      check_eq($sformatf("m1 stream instr %0d", i), c_out_instr, 32'h1000 + i);
    end
    in_valid = 1'b0;
    tick();
    check_eq("m1 stream end valid", c_out_valid, 0);

    // Flush with both entries full and a beat on the input.
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00c1, 32'h4000, 1'b1, 5'd1);
    tick();
    drive(1'b1, 32'h0000_00d1, 32'h4004, 1'b1, 5'd1);
    tick();
    check_eq("m1 pre-flush occ", c_occ, 2);
    drive(1'b1, 32'h0000_00e1, 32'h4008, 1'b1, 5'd7);
    flush = 1'b1;
    tick();
    check_eq("m1 flush occ", c_occ, 0);
    check_eq("m1 flush valid", c_out_valid, 0);
    check_eq("m1 flush in_ready", c_in_ready, 1);
    check_eq("m1 flush instr", c_out_instr, 0);
    check_eq("m1 flush pc", c_out_pc, 32'h4008);
    check_eq("m1 flush bd", c_out_bd, 0);
    check_eq("m1 flush exc", c_out_exc, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("m1 post-flush valid 1", c_out_valid, 0);
    tick();
    check_eq("m1 post-flush valid 2", c_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage CPU. It is the generalised successor to the fixed IF/ID latch. It carries instruction, PC, delay-slot flag and exception code, with a valid bit, stall hold and flush-to-bubble. MODE selects one of two behaviours:
- MODE=0: classic stall-enable register for the F/D, D/E, E/M and M/W boundaries.
- MODE=1: valid/ready handshake stage with a 2-entry skid buffer, for decoupled (multi-cycle MDU/memory) boundaries.

Parameters:
- INSTR_W, 32, instruction payload width.
- PC_W, 32, PC width.
- EXC_W, 5, exception code width.
- RESET_PC, 32'h0000_3000, out_pc value after reset and carried on bubbles created by reset.
- MODE, 0, 0 = stall-enable register, 1 = handshake with 2-entry skid.
- FLUSH_OVER_STALL, 1, MODE=0 only. 1 = flush beats stall, 0 = stall beats flush.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- stall, input, 1, MODE=0: hold contents. Ignored in MODE=1.
- flush, input, 1, discard held/incoming instruction(s) and insert a bubble.
- in_valid, input, 1, upstream beat is valid.
- in_ready, output, 1, stage accepts a beat this cycle.
- in_instr, input, INSTR_W, instruction.
- in_pc, input, PC_W, PC.
- in_bd, input, 1, instruction is in a branch delay slot.
- in_exc, input, EXC_W, exception code (0 = none).
- out_valid, output, 1, out_* hold a valid instruction.
- out_ready, input, 1, MODE=1: downstream accepts. Ignored in MODE=0.
- out_instr, output, INSTR_W, registered instruction.
- out_pc, output, PC_W, registered PC.
- out_bd, output, 1, registered delay-slot flag.
- out_exc, output, EXC_W, registered exception code.
- occupancy, output, 2, number of held valid beats (0..1 in MODE=0, 0..2 in MODE=1).

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, out_instr=0, out_pc=RESET_PC, out_bd=0, out_exc=0.
  - Skid entry cleared; occupancy=0.
  - in_ready=1 in MODE=1; in_ready=~stall in MODE=0.
  - Deassertion takes effect at the next rising edge.
- All outputs come straight from registers except in_ready in MODE=0.
- MODE=0, per-edge priority: reset > (flush/stall per FLUSH_OVER_STALL) > load.
  - Load (stall=0, flush=0): out_* <= in_*, out_valid <= in_valid. Latency 1 cycle.
  - Stall (taking priority): all outputs hold.
  - Flush (taking priority): bubble. out_instr=0 (nop), out_valid=0, out_bd=0, out_exc=0, out_pc <= in_pc (keeps a valid EPC candidate).
  - stall=1, flush=1: FLUSH_OVER_STALL=1 gives a bubble; 0 gives hold.
  - in_ready = ~stall, combinational. occupancy = {1'b0, out_valid}.
- MODE=1 storage and handshake:
  - Two entries: main (drives out_*) and skid. occupancy in 0..2.
  - in_ready = (skid empty), registered. It drops the cycle after the main entry stalls with a beat arriving.
  - Accept = in_valid & in_ready. Emit = out_valid & out_ready.
  - Zero-bubble throughput: with out_ready held high, one beat per cycle passes with 1-cycle latency.
- MODE=1 occupancy transitions, with no flush:
  - 0: on accept, main <= in, occupancy 1.
  - 1, accept & emit: main <= in, occupancy stays 1.
  - 1, accept & ~emit: skid <= in, occupancy 2, in_ready 0 next cycle.
  - 1, emit & ~accept: occupancy 0, out_valid 0.
  - 2, emit: main <= skid, occupancy 1, in_ready 1 next cycle. No accept is possible at occupancy 2.
  - out_* are stable while out_valid=1 & out_ready=0 (no data change under backpressure).
- MODE=1 flush:
  - Next edge: occupancy 0, out_valid 0, in_ready 1.
  - Any same-cycle input beat is dropped.
  - Payload fields take the bubble values listed for MODE=0.
  - A same-cycle emit still completes downstream.
- Exception and delay-slot fields travel with their instruction. They are never modified except zeroed on a bubble.
- Width rules: all fields are copied verbatim; no arithmetic.

Test Plan:
- MODE=0 load: reset 1→0; drive in_instr=32'h3c01_1234, in_pc=32'h3000, in_valid=1 → next edge out_instr=32'h3c011234, out_pc=32'h3000, out_valid=1, occupancy=1.
- MODE=0 stall/flush priority: load 32'h0000_0021; assert stall=1,flush=1 with in_pc=32'h3008. FLUSH_OVER_STALL=1 → out_instr=0, out_valid=0, out_pc=32'h3008. FLUSH_OVER_STALL=0 → outputs unchanged.
- Async reset mid-operation: assert reset between edges with out_valid=1 → out_valid=0 and out_pc=32'h3000 immediately, before the next clock edge.
- MODE=1 skid fill/drain: out_ready=0; send beats A,B on consecutive cycles → occupancy=2, in_ready=0, out_instr=A. Raise out_ready → A then B emitted on consecutive cycles, occupancy returns to 0, in_ready=1 the cycle after the A emit.
- MODE=1 streaming: out_ready=1; 8 back-to-back beats PC 32'h3000..32'h301c → out_valid continuous for 8 cycles, 1-cycle latency, order preserved, in_ready never 0.
- MODE=1 flush with occupancy=2 and in_valid=1 → next edge occupancy=0, out_valid=0, in_ready=1; the flushed beats never appear at the output.
